// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Multi-cycle control unit for an RV32I core. Decodes the opcode held in the
// instruction register into the datapath control set and walks each
// instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK.
// Illegal opcodes and memory accesses that never complete park the FSM in a
// terminal TRAP state until reset.
//
// Optional feature macro: CTRL_MULDIV_EN
//   Defined   : R-type with Funct7 = 7'b0000001 detours EXECUTE -> MULDIV and
//               waits (without timeout) for muldiv_done before WRITEBACK.
//   Undefined : no MULDIV state; Funct7 and muldiv_done are ignored.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   Opcode, Funct7      fields of the instruction held in IR
//   stall_i             freeze FSM, flags and counters (ignored in TRAP)
//   imem_ready          instruction memory data valid this cycle
//   dmem_ready          data memory access complete this cycle
//   muldiv_done         multi-cycle MUL/DIV result valid
//   imem_req, dmem_req  memory requests (held for the whole FETCH / MEM)
//   IRWrite, PCWrite,
//   RegWrite            single-cycle strobes
//   ALUSrc ... Con_LUI,
//   ALUOp               registered decode flags, stable EXECUTE..next DECODE
//   MemRead, MemWrite   MEM-phase access type
//   trap                sticky fault indication
//   retired_cnt         completed-instruction counter (wraps)
//   o_dbg_state         current FSM state encoding
//
// Handshake: a request (imem_req / dmem_req) stays high every cycle of its
// state; the access completes in the first unstalled cycle in which the
// matching ready is sampled high, and the FSM leaves the state on that edge.
// Ready is ignored while stalled and outside the requesting state.
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int OPCODE_W    = 7,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [6:0]          Funct7,
    input  logic                stall_i,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                muldiv_done,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegtoMem,
    output logic                Branch,
    output logic                Con_Jalr,
    output logic                Con_Jal,
    output logic                Mem,
    output logic                OpI,
    output logic                Con_AUIPC,
    output logic                Con_LUI,
    output logic [1:0]          ALUOp,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                trap,
    output logic [CNT_W-1:0]    retired_cnt,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
`ifdef CTRL_MULDIV_EN
        S_MULDIV    = 3'd6,
`endif
        S_TRAP      = 3'd5
    } state_t;

    // Everything latched in DECODE and held until the next DECODE.
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regtomem;
        logic       branch;
        logic       jalr;
        logic       jal;
        logic       mem;
        logic       opi;
        logic       auipc;
        logic       lui;
        logic [1:0] aluop;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
    } flags_t;

    localparam logic [OPCODE_W-1:0] OP_R     = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I     = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BR    = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(7'b1101111);
    localparam logic [OPCODE_W-1:0] OP_JALR  = OPCODE_W'(7'b1100111);
    localparam logic [OPCODE_W-1:0] OP_LUI   = OPCODE_W'(7'b0110111);
    localparam logic [OPCODE_W-1:0] OP_AUIPC = OPCODE_W'(7'b0010111);

    // The wait counter holds 0 .. MEM_TIMEOUT-1; the last value is the
    // final cycle in which ready may still rescue the access.
    localparam int                TO_W  = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]   LIMIT = TO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_wait;
    logic [TO_W-1:0]   w_wait_next;
    flags_t            r_flags;
    flags_t            w_dec;
    logic              w_legal;
    logic [CNT_W-1:0]  r_retired;
    logic              w_irwrite;
    logic              w_pcwrite;
    logic              w_regwrite;
    logic              w_load_flags;
    logic              w_retire;
    logic              w_muldiv_op;

`ifdef CTRL_MULDIV_EN
    logic              r_muldiv;
    assign w_muldiv_op = (Opcode == OP_R) && (Funct7 == 7'b0000001);
`else
    logic              w_unused_ports;
    assign w_muldiv_op    = 1'b0;
    assign w_unused_ports = ^{Funct7, muldiv_done, w_muldiv_op};
`endif

    // ------------------------------------------------------------------
    // Opcode decoder (combinational, captured into r_flags in DECODE)
    // ------------------------------------------------------------------
    always_comb begin
        w_dec   = '0;
        w_legal = 1'b1;
        case (Opcode)
            OP_R: begin
                w_dec.aluop    = 2'b10;
                w_dec.regwrite = 1'b1;
            end
            OP_I: begin
                w_dec.alusrc   = 1'b1;
                w_dec.opi      = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_LW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.memtoreg = 1'b1;
                w_dec.mem      = 1'b1;
                w_dec.memread  = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_SW: begin
                w_dec.alusrc   = 1'b1;
                w_dec.regtomem = 1'b1;
                w_dec.mem      = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            OP_BR: begin
                w_dec.branch   = 1'b1;
                w_dec.aluop    = 2'b01;
            end
            OP_JAL: begin
                w_dec.jal      = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_JALR: begin
                w_dec.jalr     = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_LUI: begin
                w_dec.lui      = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.auipc    = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_wait_next  = r_wait;
        w_irwrite    = 1'b0;
        w_pcwrite    = 1'b0;
        w_regwrite   = 1'b0;
        w_load_flags = 1'b0;
        w_retire     = 1'b0;

        if (r_state == S_TRAP) begin
            w_next = S_TRAP;
        end else if (!stall_i) begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        w_irwrite   = 1'b1;
                        w_next      = S_DECODE;
                        w_wait_next = '0;
                    end else if (r_wait == LIMIT) begin
                        w_next      = S_TRAP;
                        w_wait_next = '0;
                    end else begin
                        w_wait_next = r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    w_load_flags = 1'b1;
                    w_next       = w_legal ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
`ifdef CTRL_MULDIV_EN
                    if (r_muldiv)
                        w_next = S_MULDIV;
                    else
`endif
                    if (r_flags.mem)
                        w_next = S_MEM;
                    else
                        w_next = S_WRITEBACK;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        w_next      = S_WRITEBACK;
                        w_wait_next = '0;
                    end else if (r_wait == LIMIT) begin
                        w_next      = S_TRAP;
                        w_wait_next = '0;
                    end else begin
                        w_wait_next = r_wait + 1'b1;
                    end
                end
`ifdef CTRL_MULDIV_EN
                S_MULDIV: begin
                    // Multiplier latency is data dependent: no timeout here.
                    if (muldiv_done)
                        w_next = S_WRITEBACK;
                end
`endif
                S_WRITEBACK: begin
                    w_pcwrite  = 1'b1;
                    w_regwrite = r_flags.regwrite;
                    w_retire   = 1'b1;
                    w_next     = S_FETCH;
                end
                default: begin
                    w_next = S_TRAP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, flags and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_flags   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_load_flags)
                r_flags <= w_legal ? w_dec : '0;
            if (w_retire)
                r_retired <= r_retired + 1'b1;
        end
    end

`ifdef CTRL_MULDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_muldiv <= 1'b0;
        else if (w_load_flags)
            r_muldiv <= w_legal && w_muldiv_op;
    end
`endif

    // ------------------------------------------------------------------
    // Outputs. Requests and strobes are qualified with rst_n so nothing
    // is asserted while reset is held, even though the FSM already sits
    // in FETCH during reset.
    // ------------------------------------------------------------------
    assign imem_req    = rst_n && (r_state == S_FETCH);
    assign dmem_req    = rst_n && (r_state == S_MEM);
    assign MemRead     = dmem_req && r_flags.memread;
    assign MemWrite    = dmem_req && r_flags.memwrite;
    assign IRWrite     = rst_n && w_irwrite;
    assign PCWrite     = rst_n && w_pcwrite;
    assign RegWrite    = rst_n && w_regwrite;
    assign trap        = (r_state == S_TRAP);

    assign ALUSrc      = r_flags.alusrc;
    assign MemtoReg    = r_flags.memtoreg;
    assign RegtoMem    = r_flags.regtomem;
    assign Branch      = r_flags.branch;
    assign Con_Jalr    = r_flags.jalr;
    assign Con_Jal     = r_flags.jal;
    assign Mem         = r_flags.mem;
    assign OpI         = r_flags.opi;
    assign Con_AUIPC   = r_flags.auipc;
    assign Con_LUI     = r_flags.lui;
    assign ALUOp       = r_flags.aluop;

    assign retired_cnt = r_retired;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam int REC_W = 45;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [6:0]  Opcode;
    logic [6:0]  Funct7;
    logic        stall_i;
    logic        imem_ready;
    logic        dmem_ready;
    logic        muldiv_done;
    logic        imem_req, dmem_req, IRWrite, PCWrite;
    logic        ALUSrc, MemtoReg, RegtoMem, Branch, Con_Jalr, Con_Jal;
    logic        Mem, OpI, Con_AUIPC, Con_LUI;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, RegWrite, trap;
    logic [31:0] retired_cnt;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [REC_W-1:0] exp_q[$];

    multicycle_controller #(
        .OPCODE_W    (7),
        .MEM_TIMEOUT (16),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .Funct7      (Funct7),
        .stall_i     (stall_i),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .muldiv_done (muldiv_done),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .RegtoMem    (RegtoMem),
        .Branch      (Branch),
        .Con_Jalr    (Con_Jalr),
        .Con_Jal     (Con_Jal),
        .Mem         (Mem),
        .OpI         (OpI),
        .Con_AUIPC   (Con_AUIPC),
        .Con_LUI     (Con_LUI),
        .ALUOp       (ALUOp),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .trap        (trap),
        .retired_cnt (retired_cnt),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [9:0]  flags_now;
    logic [19:0] outs_now;
    assign flags_now = {ALUSrc, MemtoReg, RegtoMem, Branch, Con_Jalr, Con_Jal,
                        Mem, OpI, Con_AUIPC, Con_LUI};
    assign outs_now  = {imem_req, dmem_req, IRWrite, PCWrite, flags_now, ALUOp,
                        MemRead, MemWrite, RegWrite, trap};

    function automatic logic [REC_W-1:0] rec(input logic rw, input logic [9:0] fl,
                                             input logic [1:0] aop, input int mr,
                                             input int mw, input int lat, input int cnt);
        return {rw, fl, aop, 8'(mr), 8'(mw), 8'(lat), 8'(cnt)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // One record per retired instruction, taken in the WRITEBACK cycle.
    bit in_instr = 0;
    int lat_c = 0, mr_c = 0, mw_c = 0;

    always @(negedge clk) begin
        logic [REC_W-1:0] act;
        logic [REC_W-1:0] exp;
        if (!rst_n) begin
            in_instr = 0;
        end else begin
            if (imem_req && !in_instr) begin
                in_instr = 1;
                lat_c = 0; mr_c = 0; mw_c = 0;
            end
            if (in_instr) begin
                lat_c++;
                if (MemRead)  mr_c++;
                if (MemWrite) mw_c++;
            end
            if (PCWrite) begin
                act = rec(RegWrite, flags_now, ALUOp, mr_c, mw_c, lat_c, int'(retired_cnt));
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wb_unexpected got %h", act);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_err++;
                        $display("FAIL wb_record got %h exp %h", act, exp);
                    end
                end
                in_instr = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; stall_i = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        muldiv_done = 1'b0; Opcode = OP_R; Funct7 = 7'd0;
        #1;
        check("reset_outs", 64'(outs_now), 64'd0);
        check("reset_cnt", 64'(retired_cnt), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("release_fetch", 64'({imem_req, IRWrite, PCWrite, RegWrite, trap}), 64'b10000);
    endtask

    // Runs one instruction from FETCH through WRITEBACK. fw/mw are the
    // not-ready cycles before imem/dmem ready; a stall of st_len cycles is
    // inserted in MEM once mw_cnt reaches st_at, and wb_st stall cycles in
    // WRITEBACK after a memory access.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int st_at, input int st_len, input int wb_st,
                             input logic [REC_W-1:0] exp);
        int fcnt = 0;
        int mcnt = 0;
        int st_left = st_len;
        int wb_left = wb_st;
        int guard = 0;
        bit done = 0;
        bit in_wb = 0;
        exp_q.push_back(exp);
        Opcode = op;
        while (!done && guard < 100) begin
            stall_i = 1'b0;
            if (dmem_req && mcnt == st_at && st_left > 0) begin
                stall_i = 1'b1; st_left--;
            end
            if (in_wb && wb_left > 0) begin
                stall_i = 1'b1; wb_left--;
            end
            imem_ready = imem_req && !stall_i && (fcnt == fw);
            dmem_ready = dmem_req && !stall_i && (mcnt == mw);
            #1;
            done = PCWrite;
            if (!stall_i) begin
                if (imem_req) fcnt++;
                if (dmem_req) begin
                    in_wb = dmem_ready;
                    mcnt++;
                end
            end
            @(posedge clk); #1;
            guard++;
        end
        stall_i = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL run_instr_timeout op=%b", op);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        do_reset();

        // Main decode table, zero-wait memory unless noted.
        run_instr(OP_R,     0, 0, -1, 0, 0, rec(1, 10'b0000000000, 2'b10, 0, 0, 4, 0));
        check("cnt_after_add", 64'(retired_cnt), 64'd1);
        run_instr(OP_LW,    0, 3, -1, 0, 0, rec(1, 10'b1100001000, 2'b00, 4, 0, 8, 1));
        run_instr(OP_SW,    0, 0, -1, 0, 0, rec(0, 10'b1010001000, 2'b00, 0, 1, 5, 2));
        run_instr(OP_JALR,  0, 0, -1, 0, 0, rec(1, 10'b1000100000, 2'b00, 0, 0, 4, 3));
        run_instr(OP_BR,    0, 0, -1, 0, 0, rec(0, 10'b0001000000, 2'b01, 0, 0, 4, 4));
        run_instr(OP_JAL,   0, 0, -1, 0, 0, rec(1, 10'b0000010000, 2'b00, 0, 0, 4, 5));
        run_instr(OP_I,     2, 0, -1, 0, 0, rec(1, 10'b1000000100, 2'b00, 0, 0, 6, 6));
        run_instr(OP_LUI,   0, 0, -1, 0, 0, rec(1, 10'b1000000001, 2'b00, 0, 0, 4, 7));
        run_instr(OP_AUIPC, 0, 0, -1, 0, 0, rec(1, 10'b1000000010, 2'b00, 0, 0, 4, 8));
        check("cnt_after_table", 64'(retired_cnt), 64'd9);

        // Fetch ready on the 16th waiting cycle still proceeds.
        run_instr(OP_R, 15, 0, -1, 0, 0, rec(1, 10'b0000000000, 2'b10, 0, 0, 19, 9));
        check("no_trap_at_limit", 64'(trap), 64'd0);

        // Long stall mid-MEM must freeze the timeout; stall in WRITEBACK
        // defers the strobes.
        run_instr(OP_LW, 0, 3, 1, 14, 2, rec(1, 10'b1100001000, 2'b00, 18, 0, 24, 10));
        check("cnt_after_stall", 64'(retired_cnt), 64'd11);

        // Stall in EXECUTE, then reset while stalled.
        Opcode = OP_R; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(posedge clk); #1;
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("exec_stall_hold", 64'({ALUOp, PCWrite, RegWrite, IRWrite, imem_req}), 64'b100000);
        end
        rst_n = 1'b0;
        #1;
        check("reset_in_exec_outs", 64'(outs_now), 64'd0);
        check("reset_in_exec_cnt", 64'(retired_cnt), 64'd0);
        do_reset();
        run_instr(OP_R, 0, 0, -1, 0, 0, rec(1, 10'b0000000000, 2'b10, 0, 0, 4, 0));

        // Illegal opcode traps one cycle after DECODE and stays trapped.
        Opcode = OP_BAD; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check("illegal_decode_no_trap", 64'(trap), 64'd0);
        @(posedge clk); #1;
        check("illegal_trap_set", 64'(trap), 64'd1);
        for (int i = 0; i < 20; i++) begin
            stall_i = i[0]; imem_ready = 1'b1; dmem_ready = 1'b1;
            #1;
            check("trap_hold", 64'({trap, imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemRead, MemWrite}),
                  64'b10000000);
            @(posedge clk); #1;
        end
        stall_i = 1'b0;
        do_reset();
        check("trap_cleared", 64'(trap), 64'd0);

        // Fetch timeout: 16 waiting FETCH cycles then TRAP.
        imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("fetch_wait_no_trap", 64'({trap, imem_req}), 64'b01);
            @(posedge clk); #1;
        end
        check("fetch_timeout_trap", 64'({trap, imem_req}), 64'b10);
        do_reset();

        // Data memory timeout: exactly 16 MEM cycles before TRAP.
        Opcode = OP_LW; imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40 && !trap; i++) begin
            if (dmem_req) cnt++;
            @(posedge clk); #1;
        end
        check("mem_timeout_cycles", 64'(cnt), 64'd16);
        check("mem_timeout_trap", 64'({trap, dmem_req, MemRead}), 64'b100);

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
